sdram_read_ppfifo: RTL and testbench

// - Ping-pong read buffer between the SDRAM read engine and the application/wishbone read path.
// - Write side takes 32-bit words from the read engine through its FIFO handshake:

---
 rtl/sdram_read_ppfifo_pkg.sv | 14 +
 rtl/sdram_ppfifo_bank.sv | 66 ++++++
 rtl/sdram_read_ppfifo.sv | 120 ++++++++++++
 tb/tb_sdram_read_ppfifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_read_ppfifo_pkg.sv
// Shared constants for the SDRAM read ping-pong FIFO: bank state encodings and default depth.
package sdram_read_ppfifo_pkg;

    localparam int PPF_DEPTH      = 512;
    localparam int PPF_DEPTH_BITS = 9;

    localparam logic [1:0] PPF_EMPTY     = 2'd0;
    localparam logic [1:0] PPF_FILLING   = 2'd1;
    localparam logic [1:0] PPF_COMMITTED = 2'd2;
    localparam logic [1:0] PPF_DRAINING  = 2'd3;

    typedef logic [31:0] ppf_word_t;

endpackage

// File: rtl/sdram_ppfifo_bank.sv
// One ping-pong bank: storage, fill count, drain pointer and the EMPTY/FILLING/COMMITTED/DRAINING state.
module sdram_ppfifo_bank
    import sdram_read_ppfifo_pkg::*;
#(
    parameter int DEPTH      = PPF_DEPTH,
    parameter int DEPTH_BITS = PPF_DEPTH_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                activate,
    input  logic                write,
    input  ppf_word_t           wr_data,
    input  logic                start_drain,
    input  logic                pop,
    output ppf_word_t           data,
    output logic [DEPTH_BITS:0] count,
    output logic [1:0]          state
);

    ppf_word_t           mem [DEPTH];
    logic [DEPTH_BITS:0] rd_ptr;
    logic                we;
    logic                last_pop;

    assign we       = write && (state == PPF_FILLING) && (count != (DEPTH_BITS + 1)'(DEPTH));
    assign last_pop = pop && ((rd_ptr + (DEPTH_BITS + 1)'(1)) == count);
    assign data     = mem[rd_ptr[DEPTH_BITS-1:0]];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[count[DEPTH_BITS-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PPF_EMPTY;
            count  <= '0;
            rd_ptr <= '0;
        end else begin
            case (state)
                PPF_EMPTY: begin
                    if (activate) state <= PPF_FILLING;
                end
                PPF_FILLING: begin
                    if (we) count <= count + (DEPTH_BITS + 1)'(1);
                    // A word written on the deactivate cycle still makes the bank worth committing.
                    if (!activate) state <= ((count != '0) || we) ? PPF_COMMITTED : PPF_EMPTY;
                end
                default: begin
                    if ((state == PPF_DRAINING) || start_drain) begin
                        if (last_pop) begin
                            state  <= PPF_EMPTY;
                            count  <= '0;
                            rd_ptr <= '0;
                        end else begin
                            state <= PPF_DRAINING;
                            if (pop) rd_ptr <= rd_ptr + (DEPTH_BITS + 1)'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/sdram_read_ppfifo.sv
// Ping-pong read buffer: the SDRAM read engine fills one bank while the application drains the other.
module sdram_read_ppfifo
    import sdram_read_ppfifo_pkg::*;
#(
    parameter int DEPTH      = PPF_DEPTH,
    parameter int DEPTH_BITS = PPF_DEPTH_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_reset,
    output logic [1:0]  wr_ready,
    input  logic [1:0]  wr_activate,
    output logic [23:0] wr_size,
    input  logic        wr_strobe,
    input  logic [31:0] wr_data,
    input  logic        rd_request,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    input  logic        rd_accept,
    output logic        starved,
    output logic        overflow
);

    logic                flush;
    logic                act0, act1;
    logic                we0, we1;
    logic                fill0, fill1, cm0, cm1, drn0, drn1;
    logic                com0, com1;
    logic                full0, full1;
    logic                sel_com, src, src_avail, load;
    logic                start0, start1, pop0, pop1;
    logic                oldest;
    ppf_word_t           data0, data1;
    logic [DEPTH_BITS:0] count0, count1;
    logic [1:0]          state0, state1;

    assign flush   = rst || wr_reset;
    assign wr_size = 24'(DEPTH);

    // Both activate bits high is illegal; bank 0 wins.
    assign act0 = wr_activate[0];
    assign act1 = wr_activate[1] && !wr_activate[0];

    assign fill0 = (state0 == PPF_FILLING);
    assign fill1 = (state1 == PPF_FILLING);
    assign cm0   = (state0 == PPF_COMMITTED);
    assign cm1   = (state1 == PPF_COMMITTED);
    assign drn0  = (state0 == PPF_DRAINING);
    assign drn1  = (state1 == PPF_DRAINING);

    assign we0   = wr_strobe && fill0;
    assign we1   = wr_strobe && !fill0 && fill1;
    assign full0 = (count0 == (DEPTH_BITS + 1)'(DEPTH));
    assign full1 = (count1 == (DEPTH_BITS + 1)'(DEPTH));
    assign com0  = fill0 && !act0 && ((count0 != '0) || we0);
    assign com1  = fill1 && !act1 && ((count1 != '0) || we1);

    assign wr_ready = {state1 == PPF_EMPTY, state0 == PPF_EMPTY};

    // The committed bank is handed straight to the output register so the first word costs one cycle.
    assign sel_com   = (cm0 && cm1) ? oldest : cm1;
    assign src       = drn0 ? 1'b0 : (drn1 ? 1'b1 : sel_com);
    assign src_avail = drn0 || drn1 || cm0 || cm1;
    assign start0    = !drn0 && !drn1 && cm0 && !sel_com;
    assign start1    = !drn0 && !drn1 && cm1 && sel_com;
    assign load      = src_avail && (!rd_valid || rd_accept);
    assign pop0      = load && !src;
    assign pop1      = load && src;

    assign starved = rd_request && !rd_valid && !src_avail;

    sdram_ppfifo_bank #(.DEPTH(DEPTH), .DEPTH_BITS(DEPTH_BITS)) u_bank0 (
        .clk         (clk),
        .rst         (flush),
        .activate    (act0),
        .write       (we0),
        .wr_data     (wr_data),
        .start_drain (start0),
        .pop         (pop0),
        .data        (data0),
        .count       (count0),
        .state       (state0)
    );

    sdram_ppfifo_bank #(.DEPTH(DEPTH), .DEPTH_BITS(DEPTH_BITS)) u_bank1 (
        .clk         (clk),
        .rst         (flush),
        .activate    (act1),
        .write       (we1),
        .wr_data     (wr_data),
        .start_drain (start1),
        .pop         (pop1),
        .data        (data1),
        .count       (count1),
        .state       (state1)
    );

    // oldest names the bank that committed first; it only changes when the other bank is not waiting.
    always_ff @(posedge clk) begin
        if (flush) begin
            oldest   <= 1'b0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (com0 && !cm1) oldest <= 1'b0;
            else if (com1 && !cm0) oldest <= 1'b1;

            if (wr_strobe && ((fill0 && full0) || (!fill0 && fill1 && full1))) overflow <= 1'b1;

            if (load) begin
                rd_valid <= 1'b1;
                rd_data  <= src ? data1 : data0;
            end else if (rd_accept) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_read_ppfifo.sv
// Directed bench for sdram_read_ppfifo: fill/drain, ping-pong order, overflow, empty activate, starve and flush.
module tb_sdram_read_ppfifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_reset;
    logic [1:0]  wr_ready;
    logic [1:0]  wr_activate;
    logic [23:0] wr_size;
    logic        wr_strobe;
    logic [31:0] wr_data;
    logic        rd_request;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_accept;
    logic        starved;
    logic        overflow;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_read_ppfifo dut (
        .clk         (clk),
        .rst         (rst),
        .wr_reset    (wr_reset),
        .wr_ready    (wr_ready),
        .wr_activate (wr_activate),
        .wr_size     (wr_size),
        .wr_strobe   (wr_strobe),
        .wr_data     (wr_data),
        .rd_request  (rd_request),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_accept   (rd_accept),
        .starved     (starved),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output word as seen by the reader; an invalid output shows as a marker value.
    function automatic logic [31:0] out_word();
        return rd_valid ? rd_data : 32'hDEAD_BEEF;
    endfunction

    task automatic fill(input logic [1:0] act, input logic [31:0] base, input int n);
        wr_activate = act;
        tick();
        for (int i = 0; i < n; i++) begin
            wr_strobe = 1'b1;
            wr_data   = base + 32'(i);
            tick();
        end
        wr_strobe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_reset = 1'b0; wr_activate = 2'b00; wr_strobe = 1'b0;
        wr_data = '0; rd_request = 1'b0; rd_accept = 1'b0;
        tick(); tick();
        rst = 1'b0;

        check("reset_wr_ready", 32'(wr_ready), 32'd3);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("wr_size", 32'(wr_size), 32'd512);

        // Single fill/drain of four words.
        wr_activate = 2'b01;
        tick();
        check("single_ready_drop", 32'(wr_ready), 32'd2);
        for (int i = 1; i <= 4; i++) begin
            wr_strobe = 1'b1; wr_data = 32'(i);
            tick();
        end
        wr_strobe = 1'b0; wr_activate = 2'b00;
        tick();
        check("single_commit_no_valid", 32'(rd_valid), 32'd0);
        tick();
        check("single_word1", out_word(), 32'd1);
        rd_accept = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("single_word", out_word(), 32'(k));
        end
        check("single_ready_back", 32'(wr_ready), 32'd3);
        tick();
        rd_accept = 1'b0;
        check("single_drained", 32'(rd_valid), 32'd0);

        // Ping-pong: A0..A7 in bank0, B0..B7 in bank1, then a continuous drain.
        fill(2'b01, 32'hA0, 8);
        wr_activate = 2'b00;
        tick();
        fill(2'b10, 32'hB0, 8);
        wr_activate = 2'b00;
        tick();
        rd_accept = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("pingpong_word", out_word(), (i < 8) ? 32'hA0 + 32'(i) : 32'hB0 + 32'(i - 8));
            tick();
        end
        rd_accept = 1'b0;
        check("pingpong_end", 32'(rd_valid), 32'd0);
        check("pingpong_ready", 32'(wr_ready), 32'd3);

        // Full bank plus one extra write.
        fill(2'b01, 32'h1000, 512);
        check("full_no_overflow_yet", 32'(overflow), 32'd0);
        wr_strobe = 1'b1; wr_data = 32'hDEAD_0513;
        tick();
        wr_strobe = 1'b0;
        check("overflow_set", 32'(overflow), 32'd1);
        wr_activate = 2'b00;
        tick();
        tick();
        rd_accept = 1'b1;
        for (int i = 0; i < 512; i++) begin
            check("full_word", out_word(), 32'h1000 + 32'(i));
            tick();
        end
        rd_accept = 1'b0;
        check("full_count_512", 32'(rd_valid), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Activate and release with no writes.
        wr_activate = 2'b01;
        tick();
        check("empty_act_ready", 32'(wr_ready), 32'd2);
        wr_activate = 2'b00;
        tick();
        check("empty_act_released", 32'(wr_ready), 32'd3);
        tick();
        check("empty_act_no_valid", 32'(rd_valid), 32'd0);

        // Both activate bits: bank 0 takes the write.
        wr_activate = 2'b11;
        tick();
        check("both_act_bank0", 32'(wr_ready), 32'd2);
        wr_strobe = 1'b1; wr_data = 32'h77;
        tick();
        wr_strobe = 1'b0; wr_activate = 2'b00;
        tick(); tick();
        check("both_act_word", out_word(), 32'h77);
        rd_accept = 1'b1;
        tick();
        rd_accept = 1'b0;

        // Starve, commit a 1-word bank, then flush mid-drain.
        rd_request = 1'b1;
        #1;
        check("starved_set", 32'(starved), 32'd1);
        fill(2'b10, 32'h55, 1);
        wr_activate = 2'b00;
        tick();
        check("starved_commit", 32'(starved), 32'd0);
        tick();
        check("starve_word", out_word(), 32'h55);
        check("starve_ready", 32'(wr_ready), 32'd3);
        rd_accept = 1'b1;
        tick();
        rd_accept = 1'b0;
        fill(2'b01, 32'hC0, 3);
        wr_activate = 2'b00;
        tick(); tick();
        rd_accept = 1'b1;
        tick();
        rd_accept = 1'b0;
        check("flush_pre_word", out_word(), 32'hC1);
        wr_reset = 1'b1;
        tick();
        wr_reset = 1'b0;
        check("flush_rd_valid", 32'(rd_valid), 32'd0);
        check("flush_wr_ready", 32'(wr_ready), 32'd3);
        check("flush_rd_data", rd_data, 32'd0);
        check("flush_overflow", 32'(overflow), 32'd0);
        check("flush_starved", 32'(starved), 32'd1);
        tick();
        check("flush_stays_empty", 32'(rd_valid), 32'd0);
        rd_request = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
